uart_rx_param: RTL

Next-generation AXI4-Stream UART receiver.
- Generalises the fixed 8N1 receiver to configurable data width, parity mode and stop-bit count.
- Baud rate is selected at runtime through a prescale input instead of elaboration-time frequency parameters.
- Adds break detection, per-word error tagging on tuser, and a defined overrun policy.
- Sits between the board rxd pin and the network input stream, paired with the existing transmitter.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_rx_param.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the parameterised UART receiver
//               (parity modes, tuser bit positions, receiver state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Bit positions inside m_axis_tuser
    localparam int TUSER_FRAME  = 0;
    localparam int TUSER_PARITY = 1;
    localparam int TUSER_BREAK  = 2;

    // Receiver state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Sample-tick generator. Latches max(prescale,1) while disabled
//               and, once enabled, emits a one-cycle tick every latched-
//               prescale clocks. Shared with the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] prescale,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_div;

    // A prescale of zero would never tick; treat it as one.
    assign w_div = (prescale == '0) ? DIV_WIDTH'(1) : prescale;
    assign tick  = enable && (r_cnt == '0);

    // Hold the divider loaded while disabled so the first tick lands
    // exactly one prescale period after enable rises.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_div <= DIV_WIDTH'(1);
            r_cnt <= '0;
        end else if (!enable) begin
            r_div <= w_div;
            r_cnt <= w_div - DIV_WIDTH'(1);
        end else if (r_cnt == '0) begin
            r_cnt <= r_div - DIV_WIDTH'(1);
        end else begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : AXI4-Stream UART receiver with configurable data width,
//               parity and stop bits, runtime prescale, break detection,
//               per-word error tagging and a drop-newest overrun policy.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [DIV_WIDTH-1:0]  prescale,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [2:0]            m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  break_detect
);

    localparam int c_SAMPLE_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam int c_MID      = OVERSAMPLE / 2;

    localparam logic [c_SAMPLE_W-1:0] c_S_PRE   = c_SAMPLE_W'(c_MID - 1);
    localparam logic [c_SAMPLE_W-1:0] c_S_MID   = c_SAMPLE_W'(c_MID);
    localparam logic [c_SAMPLE_W-1:0] c_S_DEC   = c_SAMPLE_W'(c_MID + 1);
    localparam logic [c_SAMPLE_W-1:0] c_S_LAST  = c_SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]    c_DATA_LAST = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]    c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    rx_state_t r_state;
    rx_state_t w_state_next;

    logic                  r_rx_meta;
    logic                  r_rxs;
    logic                  r_rxs_d;
    logic                  w_tick;
    logic                  w_busy;
    logic [c_SAMPLE_W-1:0] r_s;
    logic [c_BIT_W-1:0]    r_bitcnt;
    logic                  r_v0;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_bit;
    logic                  r_par_err;
    logic                  r_ferr;
    logic                  w_vote;
    logic                  w_dec;
    logic                  w_end;
    logic                  w_ferr;
    logic                  w_brk;
    logic                  w_complete;
    logic [2:0]            w_tuser;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [2:0]            r_tuser;
    logic                  r_tvalid;
    logic                  r_overrun;
    logic                  r_break;

    assign w_busy        = (r_state != ST_IDLE);
    assign busy          = w_busy;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tvalid = r_tvalid;
    assign overrun_error = r_overrun;
    assign break_detect  = r_break;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk      (clk),
        .arstn    (arstn),
        .enable   (w_busy),
        .prescale (prescale),
        .tick     (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, majority vote and word-completion decode.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_vote       = (r_v0 & r_v1) | (r_v0 & r_rxs) | (r_v1 & r_rxs);
        w_dec        = w_tick && (r_s == c_S_DEC);
        w_end        = w_tick && (r_s == c_S_LAST);
        w_ferr       = r_ferr | ~w_vote;
        // r_par_bit stays 0 when parity is disabled, so one test covers both.
        w_brk        = (r_data == '0) && !r_par_bit && w_ferr;
        w_tuser               = 3'b000;
        w_tuser[TUSER_FRAME]  = w_ferr;
        w_tuser[TUSER_PARITY] = r_par_err;
        w_tuser[TUSER_BREAK]  = w_brk;
        case (r_state)
            ST_IDLE: begin
                if (r_rxs_d && !r_rxs) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_dec && w_vote)  w_state_next = ST_IDLE;
                else if (w_end)       w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_end && (r_bitcnt == c_DATA_LAST))
                    w_state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // Finish mid-bit so a start edge right after the stop bit is seen.
                if (w_dec && (r_bitcnt == c_STOP_LAST)) begin
                    w_complete   = 1'b1;
                    w_state_next = w_brk ? ST_WAIT_HIGH : ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (r_rxs) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sample/bit counters, vote samples and per-frame data/error capture.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_s       <= '0;
            r_bitcnt  <= '0;
            r_v0      <= 1'b1;
            r_v1      <= 1'b1;
            r_data    <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
            r_ferr    <= 1'b0;
        end else if (r_state == ST_IDLE || r_state == ST_WAIT_HIGH) begin
            r_s       <= '0;
            r_bitcnt  <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
            r_ferr    <= 1'b0;
        end else if (w_tick) begin
            r_s <= (r_s == c_S_LAST) ? '0 : r_s + 1'b1;
            if (r_s == c_S_PRE) r_v0 <= r_rxs;
            if (r_s == c_S_MID) r_v1 <= r_rxs;
            if (w_dec) begin
                case (r_state)
                    ST_DATA:   r_data <= {w_vote, r_data[DATA_WIDTH-1:1]};
                    ST_PARITY: begin
                        r_par_bit <= w_vote;
                        r_par_err <= ((^r_data) ^ w_vote) != (PARITY == PAR_ODD);
                    end
                    ST_STOP:   if (!w_vote) r_ferr <= 1'b1;
                    default:   ;
                endcase
            end
            if (w_end) begin
                if ((r_state == ST_DATA && r_bitcnt != c_DATA_LAST) || r_state == ST_STOP)
                    r_bitcnt <= r_bitcnt + 1'b1;
                else
                    r_bitcnt <= '0;
            end
        end
    end

    // Single-entry output register; a completion while a word is stalled is dropped.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_tdata   <= '0;
            r_tuser   <= 3'b000;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
            r_break   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_break   <= 1'b0;
            if (w_complete) begin
                if (!r_tvalid || m_axis_tready) begin
                    r_tdata  <= r_data;
                    r_tuser  <= w_tuser;
                    r_tvalid <= 1'b1;
                    r_break  <= w_brk;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
